// File: rtl/cpu_pkg.sv
// Shared definitions for the x86-subset core: opcode bytes, sequencer states
// and the micro-op descriptor produced by op_decode.
package cpu_pkg;

   localparam logic [7:0] OP_PUSH_EBP = 8'h55;
   localparam logic [7:0] OP_MOV      = 8'h89;
   localparam logic [7:0] OP_MOV_IMM  = 8'hb8;
   localparam logic [7:0] OP_POP_EBP  = 8'h5d;
   localparam logic [7:0] OP_RET      = 8'hc3;
   localparam logic [7:0] OP_CALL     = 8'he8;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EX1, S_EX2, S_MEM, S_WB, S_HALT
   } state_t;

   typedef enum logic [1:0] {MEM_NONE, MEM_RD, MEM_WR} mem_kind_t;
   typedef enum logic [1:0] {WB_NONE, WB_REG, WB_PC} wb_kind_t;

   // two_step=0 means a single ALU phase
   typedef struct packed {
      logic      two_step;
      mem_kind_t mem;
      wb_kind_t  wb;
      logic [2:0] len;
      logic      legal;
   } uop_desc_t;

   function automatic uop_desc_t mk_desc(input logic two, input mem_kind_t m,
                                         input wb_kind_t w, input logic [2:0] l,
                                         input logic lg);
      uop_desc_t d;
      d.two_step = two;
      d.mem      = m;
      d.wb       = w;
      d.len      = l;
      d.legal    = lg;
      return d;
   endfunction

endpackage

// File: rtl/op_decode.sv
// Combinational opcode-byte to micro-op descriptor lookup; also used by ALU control.
module op_decode
   import cpu_pkg::*;
(
   input  logic [7:0] i_op,
   output uop_desc_t  o_desc
);

   always_comb begin
      o_desc = mk_desc(1'b0, MEM_NONE, WB_NONE, 3'd0, 1'b0);
      case (i_op)
         OP_PUSH_EBP: o_desc = mk_desc(1'b1, MEM_WR,   WB_REG, 3'd1, 1'b1);
         OP_MOV:      o_desc = mk_desc(1'b0, MEM_NONE, WB_REG, 3'd2, 1'b1);
         OP_MOV_IMM:  o_desc = mk_desc(1'b1, MEM_NONE, WB_REG, 3'd5, 1'b1);
         OP_POP_EBP:  o_desc = mk_desc(1'b1, MEM_RD,   WB_REG, 3'd1, 1'b1);
         OP_RET:      o_desc = mk_desc(1'b1, MEM_RD,   WB_PC,  3'd1, 1'b1);
         OP_CALL:     o_desc = mk_desc(1'b1, MEM_WR,   WB_PC,  3'd5, 1'b1);
         default:     ;
      endcase
   end

endmodule

// File: rtl/instr_sequencer.sv
// Micro-sequencer: fetch, decode, ALU phase strobes, memory handshake, writeback.
// All control outputs decode from the state register so reset clears them at once.
module instr_sequencer
   import cpu_pkg::*;
#(
   parameter int OPE_W = 32,
   parameter int LEN_W = 3
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             run,
   output logic             fetch_req,
   input  logic             fetch_ack,
   input  logic [OPE_W-1:0] ope_in,
   output logic [OPE_W-1:0] ope,
   output logic             alu_step1,
   output logic             alu_step2,
   output logic             mem_req,
   output logic             mem_we,
   input  logic             mem_ack,
   output logic             reg_we,
   output logic             pc_load,
   output logic [LEN_W-1:0] pc_adv,
   output logic             instr_done,
   output logic             halted
);

   state_t           r_state, w_next;
   logic [OPE_W-1:0] r_ope;
   uop_desc_t        w_desc;

   // Descriptor is looked up from the latched word, which is stable DECODE..WB
   op_decode u_dec (
      .i_op   (r_ope[OPE_W-1 -: 8]),
      .o_desc (w_desc)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_ope   <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_FETCH && fetch_ack)
            r_ope <= ope_in;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (run) w_next = S_FETCH;
         S_FETCH:  if (fetch_ack) w_next = S_DECODE;
         S_DECODE: w_next = w_desc.legal ? S_EX1 : S_HALT;
         S_EX1: begin
            if (w_desc.two_step)          w_next = S_EX2;
            else if (w_desc.mem != MEM_NONE) w_next = S_MEM;
            else                          w_next = S_WB;
         end
         S_EX2:    w_next = (w_desc.mem != MEM_NONE) ? S_MEM : S_WB;
         S_MEM:    if (mem_ack) w_next = S_WB;
         S_WB:     w_next = run ? S_FETCH : S_IDLE;
         S_HALT:   w_next = S_HALT;
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      fetch_req  = 1'b0;
      alu_step1  = 1'b0;
      alu_step2  = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      reg_we     = 1'b0;
      pc_load    = 1'b0;
      pc_adv     = '0;
      instr_done = 1'b0;
      halted     = 1'b0;
      case (r_state)
         S_FETCH: fetch_req = 1'b1;
         S_EX1:   alu_step1 = 1'b1;
         S_EX2:   alu_step2 = 1'b1;
         S_MEM: begin
            mem_req = 1'b1;
            mem_we  = (w_desc.mem == MEM_WR);
         end
         S_WB: begin
            reg_we     = (w_desc.wb == WB_REG);
            pc_load    = (w_desc.wb == WB_PC);
            pc_adv     = LEN_W'(w_desc.len);
            instr_done = 1'b1;
         end
         S_HALT:  halted = 1'b1;
         default: ;
      endcase
   end

   assign ope = r_ope;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with an instruction-level reference model.
module tb_instr_sequencer;

   logic        clock = 1'b0, reset_n = 1'b0, run = 1'b0;
   logic        fetch_ack = 1'b0, mem_ack = 1'b0;
   logic [31:0] ope_in = '0;
   logic        fetch_req, alu_step1, alu_step2, mem_req, mem_we;
   logic        reg_we, pc_load, instr_done, halted;
   logic [31:0] ope;
   logic [2:0]  pc_adv;

   instr_sequencer #(.OPE_W(32), .LEN_W(3)) dut (
      .clock(clock), .reset_n(reset_n), .run(run),
      .fetch_req(fetch_req), .fetch_ack(fetch_ack), .ope_in(ope_in), .ope(ope),
      .alu_step1(alu_step1), .alu_step2(alu_step2),
      .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
      .reg_we(reg_we), .pc_load(pc_load), .pc_adv(pc_adv),
      .instr_done(instr_done), .halted(halted)
   );

   always #5 clock = ~clock;

   int n_cmp = 0, n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Architectural meaning of each opcode; mem: 0 none, 1 read, 2 write
   typedef struct {bit legal; int steps; int mem; bit wb_reg; bit wb_pc; int len;} ref_t;

   function automatic ref_t ref_desc(input logic [7:0] op);
      ref_t r;
      r = '{0, 0, 0, 0, 0, 0};
      case (op)
         8'h55: r = '{1, 2, 2, 1, 0, 1};
         8'h89: r = '{1, 1, 0, 1, 0, 2};
         8'hb8: r = '{1, 2, 0, 1, 0, 5};
         8'h5d: r = '{1, 2, 1, 1, 0, 1};
         8'hc3: r = '{1, 2, 1, 0, 1, 1};
         8'he8: r = '{1, 2, 2, 0, 1, 5};
         default: ;
      endcase
      return r;
   endfunction

   logic [31:0] prog[$];
   logic [7:0]  model_q[$];
   int          mem_wait = 0;
   int          mcnt = 0;

   // Fetch/memory responder: acks observed requests, fetch with no wait
   initial forever begin
      @(negedge clock);
      if (!reset_n) begin
         fetch_ack = 1'b0; mem_ack = 1'b0; mcnt = 0;
      end else begin
         if (fetch_req) begin
            ope_in = (prog.size() > 0) ? prog.pop_front() : 32'h8900_0000;
            fetch_ack = 1'b1;
            model_q.push_back(ope_in[31:24]);
         end else fetch_ack = 1'b0;
         if (mem_req) begin
            mem_ack = (mcnt >= mem_wait);
            mcnt++;
         end else begin
            mem_ack = 1'b0; mcnt = 0;
         end
      end
   end

   int  s1c, s2c, memc, fc, cyc;
   bit  in_instr, halt_seen, memwe_first;
   int  done_cnt = 0;
   int  last_adv, last_reg_we, last_pc_load, last_memwe, last_memc, last_s2, last_lat;

   // Per-cycle compare against the instruction-level model
   initial forever begin
      ref_t r;
      logic [7:0] op;
      @(negedge clock);
      if (!reset_n) begin
         chk("reset_outputs", {fetch_req, alu_step1, alu_step2, mem_req, mem_we, reg_we,
                               pc_load, instr_done, halted, pc_adv, ope}, '0);
         in_instr = 0; halt_seen = 0; model_q.delete();
      end else begin
         chk("mutex", int'(alu_step1) + int'(alu_step2) + int'(mem_req) + int'(instr_done) <= 1, 1);
         if (halted) begin
            if (!halt_seen) begin
               halt_seen = 1;
               op = (model_q.size() > 0) ? model_q.pop_front() : 8'h00;
               r = ref_desc(op);
               chk("halt_on_illegal", r.legal, 0);
               in_instr = 0;
            end
            chk("halt_quiet", {fetch_req, alu_step1, alu_step2, mem_req, reg_we,
                               pc_load, instr_done, pc_adv}, '0);
         end else begin
            if (fetch_req && !in_instr) begin
               in_instr = 1; cyc = 0; fc = 0; s1c = 0; s2c = 0; memc = 0;
            end
            if (in_instr) cyc++;
            fc  += int'(fetch_req);
            s1c += int'(alu_step1);
            s2c += int'(alu_step2);
            if (mem_req) begin
               if (memc == 0) memwe_first = mem_we;
               else chk("mem_we_stable", mem_we, memwe_first);
               memc++;
            end
            if (instr_done) begin
               chk("queue_nonempty", model_q.size() > 0, 1);
               op = (model_q.size() > 0) ? model_q.pop_front() : 8'h00;
               r = ref_desc(op);
               chk("wb_pc_adv", pc_adv, r.len);
               chk("wb_reg_we", reg_we, r.wb_reg);
               chk("wb_pc_load", pc_load, r.wb_pc);
               chk("step1_count", s1c, 1);
               chk("step2_count", s2c, r.steps - 1);
               chk("mem_used", memc > 0, r.mem != 0);
               if (r.mem != 0) chk("mem_dir", memwe_first, r.mem == 2);
               // fetch + decode + ALU phases + memory wait + writeback
               chk("latency", cyc, fc + 1 + r.steps + memc + 1);
               last_adv = pc_adv; last_reg_we = reg_we; last_pc_load = pc_load;
               last_memwe = (memc > 0) ? int'(memwe_first) : 0;
               last_memc = memc; last_s2 = s2c; last_lat = cyc;
               done_cnt++;
               in_instr = 0;
            end else begin
               chk("no_wb_strobes", {reg_we, pc_load, pc_adv}, '0);
            end
         end
      end
   end

   task automatic wait_done(input int target, input string nm);
      int n = 0;
      while (done_cnt < target && n < 60) begin
         @(negedge clock); #1; n++;
      end
      chk(nm, done_cnt >= target, 1);
   endtask

   task automatic cyc1();
      @(negedge clock); #1;
   endtask

   initial begin
      int n, strb, done_before;
      reset_n = 0; run = 0;
      repeat (3) cyc1();
      chk("rst_halted", halted, 0);
      chk("rst_ope", ope, 0);
      chk("rst_fetch_req", fetch_req, 0);
      reset_n = 1;
      cyc1();
      chk("idle_no_fetch", fetch_req, 0);

      // 0x89, zero-wait
      prog.push_back(32'h89E5_0000); run = 1;
      cyc1();
      chk("t1_fetch_req", fetch_req, 1);
      run = 0;
      wait_done(1, "t1_done");
      chk("t1_lat", last_lat, 4);
      chk("t1_adv", last_adv, 2);
      chk("t1_reg_we", last_reg_we, 1);
      chk("t1_memc", last_memc, 0);
      chk("t1_ope", ope, 32'h89E5_0000);
      repeat (3) cyc1();
      chk("t1_idle", fetch_req, 0);

      // 0x55 with mem_ack 3 cycles late
      mem_wait = 3; prog.push_back(32'h5500_0000); run = 1;
      cyc1(); run = 0;
      wait_done(2, "t2_done");
      chk("t2_memc", last_memc, 4);
      chk("t2_memwe", last_memwe, 1);
      chk("t2_s2", last_s2, 1);
      chk("t2_adv", last_adv, 1);
      chk("t2_reg_we", last_reg_we, 1);
      chk("t2_lat", last_lat, 9);

      // call then ret back to back
      mem_wait = 0; prog.push_back(32'hE800_0000); prog.push_back(32'hC300_0000); run = 1;
      wait_done(3, "t3_call_done");
      chk("t3_call_adv", last_adv, 5);
      chk("t3_call_pc_load", last_pc_load, 1);
      chk("t3_call_reg_we", last_reg_we, 0);
      chk("t3_call_memwe", last_memwe, 1);
      cyc1(); run = 0;
      wait_done(4, "t3_ret_done");
      chk("t3_ret_adv", last_adv, 1);
      chk("t3_ret_pc_load", last_pc_load, 1);
      chk("t3_ret_reg_we", last_reg_we, 0);
      chk("t3_ret_memwe", last_memwe, 0);
      chk("t3_ret_memc", last_memc, 1);

      // run dropped during EX1 of 0xb8
      prog.push_back(32'hB800_0000); run = 1;
      n = 0;
      while (!alu_step1 && n < 20) begin cyc1(); n++; end
      chk("t5_saw_ex1", alu_step1, 1);
      run = 0;
      wait_done(5, "t5_done");
      chk("t5_adv", last_adv, 5);
      chk("t5_s2", last_s2, 1);
      cyc1();
      chk("t5_idle_a", fetch_req, 0);
      cyc1();
      chk("t5_idle_b", fetch_req, 0);

      // illegal opcode halts until reset
      prog.push_back(32'hFF00_0000); run = 1;
      n = 0;
      while (!halted && n < 10) begin cyc1(); n++; end
      chk("halt_set", halted, 1);
      strb = 0;
      repeat (20) begin
         cyc1();
         strb += int'(fetch_req | alu_step1 | alu_step2 | mem_req | reg_we | pc_load | instr_done);
      end
      chk("halt_no_strobes", strb, 0);
      chk("halt_sticky", halted, 1);
      reset_n = 0; #2;
      chk("halt_cleared", halted, 0);
      run = 0;
      cyc1(); reset_n = 1;

      // reset while waiting in MEM
      mem_wait = 1000; prog.push_back(32'h5D00_0000); run = 1;
      n = 0;
      while (!mem_req && n < 20) begin cyc1(); n++; end
      chk("t6_in_mem", mem_req, 1);
      done_before = done_cnt;
      reset_n = 0; #1;
      chk("t6_async_mem_req", mem_req, 0);
      chk("t6_no_done", instr_done, 0);
      cyc1();
      chk("t6_no_done_cnt", done_cnt, done_before);
      mem_wait = 0; prog.push_back(32'h8900_0000);
      reset_n = 1;
      @(posedge clock); #1;
      chk("t6_fetch_after_release", fetch_req, 1);
      run = 0;
      wait_done(done_before + 1, "t6_done");
      chk("t6_lat", last_lat, 4);
      repeat (2) cyc1();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
